cd_gen: RTL and testbench

Parametrised single-cycle CPU datapath: program counter, register file, ALU with zero and carry flags, immediate load, and a hardware return-address stack for subroutine call/return. It sits between the external program memory (instruction fetch by `pc`) and the control unit, which decodes `opcode` and drives the select/enable inputs. It is the successor to the fixed 8-bit/10-bit datapath, generalised in data width, PC width, register count and call depth.

---
 rtl/cd_pkg.sv | 36 +++
 rtl/ret_stack.sv | 54 +++++
 rtl/cd_gen.sv | 126 ++++++++++++
 tb/tb_cd_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cd_pkg.sv
// Shared encodings for the cd_gen datapath: instruction fields, ALU ops, select polarities.
package cd_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned OPC_LSB = 10;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned IMM_W   = 8;

    localparam logic SEL_INC = 1'b1;
    localparam logic SEL_IMM = 1'b1;

    typedef enum logic [2:0] {
        ALU_A    = 3'b000,
        ALU_NOTA = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_NEGA = 3'b110,
        ALU_NEGB = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [IDX_W-1:0] hi;
        logic [IDX_W-1:0] ra;
        logic [IDX_W-1:0] rb;
        logic [IDX_W-1:0] rd;
    } instr_t;

    // Immediate occupies the ra/rb nibbles.
    function automatic logic [IMM_W-1:0] imm_of(input instr_t i);
        return {i.ra, i.rb};
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
module ret_stack #(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [PC_W-1:0]  data,
    output logic [PC_W-1:0]  top_c,
    output logic [LVL_W-1:0] level,
    output logic             ovf_c,
    output logic             unf_c
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

    logic [PC_W-1:0]  mem [STACK_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_top;
    logic             empty;
    logic             full;

    assign sp_top = sp - PTR_W'(1);
    assign empty  = (level == '0);
    assign full   = (level == LVL_W'(STACK_DEPTH));
    assign top_c  = mem[sp_top];
    assign ovf_c  = push && !pop && full;
    assign unf_c  = pop && !push && empty;

    // Pointer/level; push+pop together replaces the top in place.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sp    <= '0;
            level <= '0;
        end else if (push && !pop) begin
            sp <= sp + PTR_W'(1);
            if (!full) level <= level + LVL_W'(1);
        end else if (pop && !push && !empty) begin
            sp    <= sp_top;
            level <= level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (push && pop) mem[sp_top] <= data;
            else if (push)   mem[sp]     <= data;
        end
    end

endmodule

// File: rtl/cd_gen.sv
// Single-cycle CPU datapath: PC, register file, ALU + flags, immediate load, return stack.
module cd_gen
    import cd_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PC_W        = 10,
    parameter int unsigned NREG        = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               s_inc,
    input  logic               s_inm,
    input  logic               we3,
    input  logic               wez,
    input  logic               wec,
    input  logic [2:0]         op_alu,
    input  logic               s_call,
    input  logic               s_ret,
    output logic [PC_W-1:0]    pc,
    output logic [OPC_W-1:0]   opcode,
    output logic               z,
    output logic               c,
    output logic               stk_ovf,
    output logic               stk_unf
);

    localparam int unsigned RI_W  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);

    instr_t            f;
    logic [RI_W-1:0]   ra, rb, rd;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] a, b, wd;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c;
    alu_op_e           op;
    logic [PC_W-1:0]   pc_inc, target, pc_next, top_c;
    logic [LVL_W-1:0]  level;
    logic              ovf_c, unf_c;

    assign f      = instr_t'(instr);
    assign opcode = f[OPC_LSB +: OPC_W];
    assign ra     = f.ra[RI_W-1:0];
    assign rb     = f.rb[RI_W-1:0];
    assign rd     = f.rd[RI_W-1:0];
    assign a      = regs[ra];
    assign b      = regs[rb];
    assign op     = alu_op_e'(op_alu);
    assign sum    = {1'b0, a} + {1'b0, b};
    assign pc_inc = pc + PC_W'(1);
    assign target = instr[PC_W-1:0];

    // ALU result and carry/no-borrow
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        case (op)
            ALU_A:    alu_r = a;
            ALU_NOTA: alu_r = ~a;
            ALU_ADD: begin
                alu_r = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
            end
            ALU_SUB: begin
                alu_r = a - b;
                alu_c = (a >= b);
            end
            ALU_AND:  alu_r = a & b;
            ALU_OR:   alu_r = a | b;
            ALU_NEGA: alu_r = '0 - a;
            ALU_NEGB: alu_r = '0 - b;
            default:  alu_r = '0;
        endcase
    end

    assign wd = (s_inm == SEL_IMM) ? DATA_W'(imm_of(f)) : alu_r;

    // Next PC; a combined call+return jumps to the target.
    always_comb begin
        pc_next = target;
        if (s_call && s_ret)      pc_next = target;
        else if (s_ret)           pc_next = (level == '0) ? '0 : top_c;
        else if (s_call)          pc_next = target;
        else if (s_inc == SEL_INC) pc_next = pc_inc;
    end

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (s_call),
        .pop   (s_ret),
        .data  (pc_inc),
        .top_c (top_c),
        .level (level),
        .ovf_c (ovf_c),
        .unf_c (unf_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= '0;
            z       <= 1'b0;
            c       <= 1'b0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            pc <= pc_next;
            if (wez)   z       <= (alu_r == '0);
            if (wec)   c       <= alu_c;
            if (ovf_c) stk_ovf <= 1'b1;
            if (unf_c) stk_unf <= 1'b1;
        end
    end

    // Register file has no reset; writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && we3) regs[rd] <= wd;
    end

endmodule

// File: tb/tb_cd_gen.sv
// Directed self-checking bench for cd_gen with default parameters.
module tb_cd_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        s_inc, s_inm, we3, wez, wec, s_call, s_ret;
    logic [2:0]  op_alu;
    logic [9:0]  pc;
    logic [5:0]  opcode;
    logic        z, c, stk_ovf, stk_unf;

    int total = 0;
    int bad   = 0;

    cd_gen dut (
        .clk     (clk),
        .reset   (reset),
        .instr   (instr),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we3     (we3),
        .wez     (wez),
        .wec     (wec),
        .op_alu  (op_alu),
        .s_call  (s_call),
        .s_ret   (s_ret),
        .pc      (pc),
        .opcode  (opcode),
        .z       (z),
        .c       (c),
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf)
    );

    always #5 clk = ~clk;

    task automatic idle();
        instr  = 16'h0000;
        s_inc  = 1'b0;
        s_inm  = 1'b0;
        we3    = 1'b0;
        wez    = 1'b0;
        wec    = 1'b0;
        op_alu = 3'b000;
        s_call = 1'b0;
        s_ret  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        total++; if (pc !== 10'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", pc); end
        total++; if ({z, c, stk_ovf, stk_unf} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {z, c, stk_ovf, stk_unf}); end
        instr = 16'hFC00;
        #1;
        total++; if (opcode !== 6'h3F) begin bad++; $display("FAIL opcode got=%h exp=3f", opcode); end
        instr = 16'h5400;
        #1;
        total++; if (opcode !== 6'h15) begin bad++; $display("FAIL opcode2 got=%h exp=15", opcode); end
        reset = 1'b1;
        idle();
    endtask

    task automatic test_pc_inc();
        idle();
        s_inc = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (pc !== 10'(i)) begin bad++; $display("FAIL pc_inc got=%h exp=%h", pc, 10'(i)); end
        end
        total++; if ({z, c, stk_ovf, stk_unf} !== 4'b0000) begin bad++; $display("FAIL inc_flags got=%b exp=0000", {z, c, stk_ovf, stk_unf}); end
        s_inc = 1'b0;
        instr = 16'h03FF;
        step();
        total++; if (pc !== 10'h3FF) begin bad++; $display("FAIL jump got=%h exp=3ff", pc); end
        s_inc = 1'b1;
        step();
        total++; if (pc !== 10'h000) begin bad++; $display("FAIL pc_wrap got=%h exp=000", pc); end
    endtask

    task automatic test_alu();
        idle();
        s_inc = 1'b1;
        s_inm = 1'b1; we3 = 1'b1;
        instr = 16'h0FF1; step();          // R1 = 0xFF
        instr = 16'h0012; step();          // R2 = 0x01
        s_inm = 1'b0; wez = 1'b1; wec = 1'b1;
        op_alu = 3'b010; instr = 16'h0123; step();   // R3 = R1 + R2
        total++; if ({z, c} !== 2'b11) begin bad++; $display("FAIL add_flags got=%b exp=11", {z, c}); end
        we3 = 1'b0;
        op_alu = 3'b000; instr = 16'h0300; step();   // pass R3
        total++; if ({z, c} !== 2'b10) begin bad++; $display("FAIL r3_zero got=%b exp=10", {z, c}); end
        op_alu = 3'b011; instr = 16'h0210; step();   // 1 - 255
        total++; if ({z, c} !== 2'b00) begin bad++; $display("FAIL sub_borrow got=%b exp=00", {z, c}); end
        instr = 16'h0120; step();                    // 255 - 1
        total++; if ({z, c} !== 2'b01) begin bad++; $display("FAIL sub_noborrow got=%b exp=01", {z, c}); end
        instr = 16'h0110; step();                    // 255 - 255
        total++; if ({z, c} !== 2'b11) begin bad++; $display("FAIL sub_equal got=%b exp=11", {z, c}); end
        wez = 1'b0; wec = 1'b0;
        op_alu = 3'b000; instr = 16'h0200; step();   // nonzero but flags held
        total++; if ({z, c} !== 2'b11) begin bad++; $display("FAIL flag_hold got=%b exp=11", {z, c}); end
        wez = 1'b1; wec = 1'b1;
        op_alu = 3'b100; instr = 16'h0120; step();   // 0xFF & 0x01
        total++; if ({z, c} !== 2'b00) begin bad++; $display("FAIL and got=%b exp=00", {z, c}); end
        op_alu = 3'b110; instr = 16'h0300; step();   // -0
        total++; if (z !== 1'b1) begin bad++; $display("FAIL nega_zero got=%b exp=1", z); end
        op_alu = 3'b001; instr = 16'h0100; step();   // ~0xFF
        total++; if (z !== 1'b1) begin bad++; $display("FAIL nota got=%b exp=1", z); end
        // read-during-write on R3 (=0): ~0 written back, old value seen this cycle
        we3 = 1'b1; op_alu = 3'b001; instr = 16'h0303; step();
        total++; if (z !== 1'b0) begin bad++; $display("FAIL rdw_old got=%b exp=0", z); end
        instr = 16'h0303; step();                    // now R3 = 0xFF, ~ gives 0
        total++; if (z !== 1'b1) begin bad++; $display("FAIL rdw_new got=%b exp=1", z); end
        we3 = 1'b0; s_inm = 1'b1; wez = 1'b1;
        op_alu = 3'b000; instr = 16'h0100; step();   // flags from ALU (R0? ra=1 -> 0xFF)
        total++; if (z !== 1'b0) begin bad++; $display("FAIL inm_flags got=%b exp=0", z); end
        idle();
    endtask

    task automatic test_call_ret();
        do_reset();
        instr = 16'h0005; step();
        total++; if (pc !== 10'h005) begin bad++; $display("FAIL goto5 got=%h exp=005", pc); end
        s_call = 1'b1; instr = 16'h0040; step();
        total++; if (pc !== 10'h040) begin bad++; $display("FAIL call got=%h exp=040", pc); end
        s_call = 1'b0; s_ret = 1'b1; instr = 16'h0000; step();
        total++; if (pc !== 10'h006) begin bad++; $display("FAIL ret got=%h exp=006", pc); end
        total++; if ({stk_ovf, stk_unf} !== 2'b00) begin bad++; $display("FAIL ret_err got=%b exp=00", {stk_ovf, stk_unf}); end
        step();
        total++; if (pc !== 10'h000 || stk_unf !== 1'b1) begin bad++; $display("FAIL level0 pc=%h unf=%b exp 000/1", pc, stk_unf); end
        idle();
    endtask

    task automatic test_overflow();
        logic [9:0] tgt [5];
        logic [9:0] exp_ret [5];
        tgt = '{10'h100, 10'h200, 10'h300, 10'h080, 10'h050};
        exp_ret = '{10'h081, 10'h301, 10'h201, 10'h101, 10'h000};
        do_reset();
        s_call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr = {6'h00, tgt[i]};
            step();
            total++; if (pc !== tgt[i]) begin bad++; $display("FAIL nest_call%0d got=%h exp=%h", i, pc, tgt[i]); end
            if (i == 3) begin
                total++; if (stk_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", stk_ovf); end
            end
        end
        total++; if (stk_ovf !== 1'b1) begin bad++; $display("FAIL ovf got=%b exp=1", stk_ovf); end
        s_call = 1'b0; s_ret = 1'b1; instr = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (pc !== exp_ret[i]) begin bad++; $display("FAIL nest_ret%0d got=%h exp=%h", i, pc, exp_ret[i]); end
        end
        total++; if ({stk_ovf, stk_unf} !== 2'b11) begin bad++; $display("FAIL ovf_unf got=%b exp=11", {stk_ovf, stk_unf}); end
        s_ret = 1'b0; s_inc = 1'b1; step();
        total++; if ({stk_ovf, stk_unf} !== 2'b11) begin bad++; $display("FAIL sticky got=%b exp=11", {stk_ovf, stk_unf}); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        instr = 16'h000F; step();
        s_call = 1'b1; instr = 16'h0007; step();     // push 0x10
        total++; if (pc !== 10'h007) begin bad++; $display("FAIL bb_call got=%h exp=007", pc); end
        s_ret = 1'b1; instr = 16'h02A0; step();      // replace top with 8
        total++; if (pc !== 10'h2A0) begin bad++; $display("FAIL bb_both got=%h exp=2a0", pc); end
        total++; if ({stk_ovf, stk_unf} !== 2'b00) begin bad++; $display("FAIL bb_err got=%b exp=00", {stk_ovf, stk_unf}); end
        s_call = 1'b0; instr = 16'h0000; step();
        total++; if (pc !== 10'h008) begin bad++; $display("FAIL bb_top got=%h exp=008", pc); end
        step();
        total++; if (pc !== 10'h000 || stk_unf !== 1'b1) begin bad++; $display("FAIL bb_level pc=%h unf=%b exp 000/1", pc, stk_unf); end
        idle();
    endtask

    task automatic test_reset_mid_call();
        do_reset();
        s_inc = 1'b1; wez = 1'b1; wec = 1'b1; op_alu = 3'b010; instr = 16'h0120; step();
        total++; if ({z, c} !== 2'b11) begin bad++; $display("FAIL pre_flags got=%b exp=11", {z, c}); end
        idle();
        s_call = 1'b1; instr = 16'h0100; step();
        instr = 16'h0200; step();
        total++; if (pc !== 10'h200) begin bad++; $display("FAIL deep got=%h exp=200", pc); end
        idle();
        reset = 1'b0; s_inm = 1'b1; we3 = 1'b1; instr = 16'h0001; step();  // write R1 suppressed
        reset = 1'b1;
        total++; if ({pc, z, c, stk_ovf, stk_unf} !== 14'h0) begin bad++; $display("FAIL mid_reset pc=%h flags=%b exp 000/0000", pc, {z, c, stk_ovf, stk_unf}); end
        idle();
        s_ret = 1'b1; step();
        total++; if (pc !== 10'h000 || stk_unf !== 1'b1) begin bad++; $display("FAIL post_reset_ret pc=%h unf=%b exp 000/1", pc, stk_unf); end
        idle();
        wez = 1'b1; op_alu = 3'b001; instr = 16'h0100; step();  // ~R1 == 0 if R1 kept 0xFF
        total++; if (z !== 1'b1) begin bad++; $display("FAIL wr_suppress got=%b exp=1", z); end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        test_reset();
        test_pc_inc();
        test_alu();
        test_call_ret();
        test_overflow();
        test_back_to_back();
        test_reset_mid_call();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
